// File: rtl/apb_reg_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Each granted transfer runs SETUP/ACCESS with a wait-state timeout, then pulses the winner's done.
module apb_reg_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  busy,
  output logic                  timeout_flag
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_gnt;
  logic [7:0]            r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_busy;
  logic                  r_timeout_flag;
  logic                  r_done0;
  logic                  r_done1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  r_err0;
  logic                  r_err1;

  logic                  w_any;
  logic                  w_pick1;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_rdata;

  // On a conflict, requester 1 wins only when requester 0 was granted last.
  assign w_any     = req0_valid | req1_valid;
  assign w_pick1   = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT - 1));
  assign w_rdata   = (r_pwrite | pslverr) ? '0 : prdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_last_grant   <= 1'b1;
      r_gnt          <= 1'b0;
      r_wait_cnt     <= '0;
      r_paddr        <= '0;
      r_psel         <= 1'b0;
      r_penable      <= 1'b0;
      r_pwrite       <= 1'b0;
      r_pwdata       <= '0;
      r_busy         <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_done0        <= 1'b0;
      r_done1        <= 1'b0;
      r_rdata0       <= '0;
      r_rdata1       <= '0;
      r_err0         <= 1'b0;
      r_err1         <= 1'b0;
    end else begin
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt        <= w_pick1;
            r_last_grant <= w_pick1;
            r_paddr      <= w_pick1 ? req1_addr  : req0_addr;
            r_pwrite     <= w_pick1 ? req1_write : req0_write;
            r_pwdata     <= w_pick1 ? req1_wdata : req0_wdata;
            r_wait_cnt   <= '0;
            r_psel       <= 1'b1;
            r_penable    <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done0   <= ~r_gnt;
            r_done1   <= r_gnt;
            r_rdata0  <= r_gnt ? '0 : w_rdata;
            r_rdata1  <= r_gnt ? w_rdata : '0;
            r_err0    <= ~r_gnt & pslverr;
            r_err1    <= r_gnt & pslverr;
            r_state   <= DONE;
          end else if (w_timeout) begin
            // Abort: a coincident pslverr is ignored; the outcome is always a timeout error.
            r_psel         <= 1'b0;
            r_penable      <= 1'b0;
            r_done0        <= ~r_gnt;
            r_done1        <= r_gnt;
            r_err0         <= ~r_gnt;
            r_err1         <= r_gnt;
            r_timeout_flag <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign paddr        = r_paddr;
  assign psel         = r_psel;
  assign penable      = r_penable;
  assign pwrite       = r_pwrite;
  assign pwdata       = r_pwdata;
  assign busy         = r_busy;
  assign timeout_flag = r_timeout_flag;
  assign req0_done    = r_done0;
  assign req1_done    = r_done1;
  assign req0_rdata   = r_rdata0;
  assign req1_rdata   = r_rdata1;
  assign req0_err     = r_err0;
  assign req1_err     = r_err1;

endmodule

// File: tb/tb_apb_reg_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grant order, bus phases and done results per cycle;
// a separate monitor compares the DUT against those predictions every cycle.
module tb_apb_reg_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int TO   = 4;
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    v  = '0;
  logic [1:0]    wr = '0;
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];
  logic          pready  = 1'b0;
  logic          pslverr = 1'b0;
  logic [DW-1:0] prdata  = '0;

  logic          req0_done, req1_done, req0_err, req1_err;
  logic [DW-1:0] req0_rdata, req1_rdata, pwdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite, busy, timeout_flag;

  apb_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_write(wr[0]), .req0_addr(ad[0]), .req0_wdata(wd[0]),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(v[1]), .req1_write(wr[1]), .req1_addr(ad[1]), .req1_wdata(wd[1]),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle expectations (phase: 0 idle, 1 setup, 2 access, 3 done) and slave responses.
  logic [1:0]    e_ph   [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  logic          e_wr   [MAXC];
  logic [DW-1:0] e_wd   [MAXC];
  logic          e_tf   [MAXC];
  logic          d_rdy  [MAXC];
  logic          d_slv  [MAXC];
  logic [DW-1:0] d_rd   [MAXC];

  typedef struct { int who; int cyc; logic [DW-1:0] rdata; logic err; } exp_t;
  typedef struct { int waits; logic slv; logic [DW-1:0] rd; } plan_t;
  exp_t  sbq   [$];
  plan_t plans [$];

  int checks = 0;
  int errors = 0;
  int free_cyc = 0;
  int last = 1;
  int rq_dcyc [2];
  bit g [2];
  bit rnd = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    v[i] = 1'b1; wr[i] = w; ad[i] = a; wd[i] = d;
  endtask

  task automatic pre();
    for (int i = 0; i < 2; i++) begin
      if (g[i] && cyc == rq_dcyc[i] + 1) begin
        v[i] = 1'b0;
        g[i] = 1'b0;
      end
      if (rnd && !v[i] && !g[i] && cyc > rq_dcyc[i] + 1 && $urandom_range(0, 2) == 0)
        issue(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
    end
  endtask

  // Grant model: free again one cycle after done; conflicts alternate starting with requester 0.
  task automatic post();
    int k, win, acc, d;
    bit abort;
    plan_t p;
    k = cyc;
    if (k >= free_cyc && (v[0] || v[1])) begin
      win  = (v[0] && v[1]) ? 1 - last : (v[1] ? 1 : 0);
      last = win;
      if (plans.size() != 0) p = plans.pop_front();
      else begin
        p.waits = ($urandom_range(0, 9) < 2) ? TO : int'($urandom_range(0, TO - 1));
        p.slv   = ($urandom_range(0, 3) == 0);
        p.rd    = $urandom;
      end
      abort = (p.waits >= TO);
      acc   = abort ? TO : p.waits + 1;
      d     = k + 2 + acc;
      if (d + 2 >= MAXC) begin
        $display("FAIL cycle_budget cyc=%0d got=%0d exp<%0d", k, d, MAXC);
        $fatal(1);
      end
      e_ph[k+1] = 2'd1;
      d_rdy[k+1] = 1'b1;
      d_slv[k+1] = 1'($urandom_range(0, 1));
      for (int j = 0; j < acc; j++) begin
        e_ph[k+2+j]  = 2'd2;
        d_rdy[k+2+j] = !abort && (j == acc - 1);
        d_slv[k+2+j] = (j == acc - 1) ? p.slv : 1'($urandom_range(0, 1));
        d_rd[k+2+j]  = (j == acc - 1) ? p.rd : $urandom;
      end
      e_ph[d]  = 2'd3;
      d_rdy[d] = 1'($urandom_range(0, 1));
      for (int c = k + 1; c < d; c++) begin
        e_addr[c] = ad[win]; e_wr[c] = wr[win]; e_wd[c] = wd[win];
      end
      if (abort) for (int c = d; c < MAXC; c++) e_tf[c] = 1'b1;
      sbq.push_back('{who: win, cyc: d,
                      rdata: (abort || wr[win] || p.slv) ? '0 : p.rd,
                      err: abort ? 1'b1 : p.slv});
      rq_dcyc[win] = d;
      g[win] = 1'b1;
      free_cyc = d + 1;
    end
    pready = d_rdy[k]; pslverr = d_slv[k]; prdata = d_rd[k];
  endtask

  task automatic tick();
    pre(); post(); @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) tick();
    chk("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  task automatic do_reset();
    int k;
    k = cyc;
    rst = 1'b1;
    v = '0;
    g[0] = 0; g[1] = 0;
    rq_dcyc[0] = -10; rq_dcyc[1] = -10;
    while (sbq.size() != 0 && sbq[$].cyc > k) void'(sbq.pop_back());
    for (int c = k + 1; c < MAXC; c++) begin
      e_ph[c] = '0; e_tf[c] = 1'b0; d_rdy[c] = 1'b0; d_slv[c] = 1'b0; d_rd[c] = '0;
    end
    free_cyc = k + 1;
    last = 1;
    pready = d_rdy[k]; pslverr = d_slv[k]; prdata = d_rd[k];
    @(negedge clk);
    rst = 1'b0;
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      int k;
      logic [1:0] ph;
      exp_t e;
      k = cyc;
      ph = e_ph[k];
      chk("psel", 64'(psel), 64'(ph == 2'd1 || ph == 2'd2));
      chk("penable", 64'(penable), 64'(ph == 2'd2));
      chk("busy", 64'(busy), 64'(ph != 2'd0));
      chk("timeout_flag", 64'(timeout_flag), 64'(e_tf[k]));
      if (ph == 2'd1 || ph == 2'd2) begin
        chk("paddr", 64'(paddr), 64'(e_addr[k]));
        chk("pwrite", 64'(pwrite), 64'(e_wr[k]));
        chk("pwdata", 64'(pwdata), 64'(e_wd[k]));
      end
      if (req0_done || req1_done || ph == 2'd3) begin
        if (sbq.size() == 0) chk("spurious_done", 64'({req1_done, req0_done}), 64'd0);
        else begin
          e = sbq.pop_front();
          chk("done_cycle", 64'(k), 64'(e.cyc));
          chk("done_who", 64'({req1_done, req0_done}), 64'(e.who ? 2 : 1));
          if (e.who == 0) begin
            chk("req0_rdata", 64'(req0_rdata), 64'(e.rdata));
            chk("req0_err", 64'(req0_err), 64'(e.err));
            chk("req1_rdata_idle", 64'(req1_rdata), 64'd0);
            chk("req1_err_idle", 64'(req1_err), 64'd0);
          end else begin
            chk("req1_rdata", 64'(req1_rdata), 64'(e.rdata));
            chk("req1_err", 64'(req1_err), 64'(e.err));
            chk("req0_rdata_idle", 64'(req0_rdata), 64'd0);
            chk("req0_err_idle", 64'(req0_err), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
    rq_dcyc[0] = -10; rq_dcyc[1] = -10;
    g[0] = 0; g[1] = 0;
    for (int c = 0; c < MAXC; c++) begin
      e_ph[c] = '0; e_addr[c] = '0; e_wr[c] = 1'b0; e_wd[c] = '0; e_tf[c] = 1'b0;
      d_rdy[c] = 1'b0; d_slv[c] = 1'b0; d_rd[c] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    free_cyc = cyc;
    mon_en = 1'b1;
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);

    // Two simultaneous-read rounds: requester 0 first each time, requester 1 right after.
    for (int r = 0; r < 2; r++) begin
      plans.push_back('{waits: 0, slv: 1'b0, rd: 32'h1111_0000 + r});
      plans.push_back('{waits: 0, slv: 1'b0, rd: 32'h2222_0000 + r});
      pre();
      issue(0, 1'b0, 8'h10, '0);
      issue(1, 1'b0, 8'h20, '0);
      post(); @(negedge clk);
      run(14);
    end

    // Zero-wait write from requester 0.
    plans.push_back('{waits: 0, slv: 1'b0, rd: 32'h5555_AAAA});
    pre(); issue(0, 1'b1, 8'h04, 32'hA5A5_0001); post(); @(negedge clk);
    run(8);

    // Requester 1 read with three wait states (last allowed cycle when TIMEOUT=4).
    plans.push_back('{waits: 3, slv: 1'b0, rd: 32'hDEAD_BEEF});
    pre(); issue(1, 1'b0, 8'h3C, '0); post(); @(negedge clk);
    run(10);

    // Slave error on a zero-wait read.
    plans.push_back('{waits: 0, slv: 1'b1, rd: 32'hCAFE_F00D});
    pre(); issue(0, 1'b0, 8'h44, '0); post(); @(negedge clk);
    run(8);

    // Timeout with pslverr raised on the abort cycle.
    plans.push_back('{waits: TO, slv: 1'b1, rd: 32'h0BAD_0BAD});
    pre(); issue(1, 1'b0, 8'h55, '0); post(); @(negedge clk);
    run(12);

    rnd = 1;
    run(600);
    rnd = 0;
    drain();

    // Reset in the middle of ACCESS after granting requester 0.
    run(3);
    plans.push_back('{waits: 3, slv: 1'b0, rd: 32'h7777_7777});
    pre(); issue(0, 1'b0, 8'h66, '0); post(); @(negedge clk);
    tick();
    do_reset();
    plans.push_back('{waits: 0, slv: 1'b0, rd: 32'h0000_00A0});
    plans.push_back('{waits: 1, slv: 1'b0, rd: 32'h0000_00A1});
    pre();
    issue(0, 1'b0, 8'h70, '0);
    issue(1, 1'b0, 8'h71, '0);
    post(); @(negedge clk);
    run(16);
    drain();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
